// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: control-word layout, field
// encodings and NZCV flag positions.
package alu_pkg;

   localparam int CW_CIN_MSB = 7;
   localparam int CW_CIN_LSB = 6;
   localparam int CW_INV_MSB = 5;
   localparam int CW_INV_LSB = 4;
   localparam int CW_BIC_BIT = 3;
   localparam int CW_OP_MSB  = 2;
   localparam int CW_OP_LSB  = 0;

   typedef enum logic [1:0] {
      CIN_ZERO     = 2'b00,
      CIN_ONE      = 2'b01,
      CIN_FLAG     = 2'b10,
      CIN_FLAG_ALT = 2'b11
   } cin_sel_e;

   typedef enum logic [1:0] {
      INV_NONE = 2'b00,
      INV_B    = 2'b01,
      INV_A    = 2'b10,
      INV_RSVD = 2'b11
   } inv_sel_e;

   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_OR    = 3'b001,
      OP_AND   = 3'b010,
      OP_MVN   = 3'b011,
      OP_XOR   = 3'b100,
      OP_MOV   = 3'b101,
      OP_ZERO0 = 3'b110,
      OP_ZERO1 = 3'b111
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry in-order output buffer with a registered ready, so the upstream
// ready never depends combinationally on out_ready. Present only with ALU_SKID_BUF_EN.
`ifdef ALU_SKID_BUF_EN
module alu_skid_buffer #(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data
);

   logic [PAYLOAD_W-1:0] head_r;
   logic [PAYLOAD_W-1:0] skid_r;
   logic [1:0]           count_r;
   logic                 ready_r;
   logic                 valid_r;
   logic                 push_s;
   logic                 pop_s;
   logic [1:0]           count_next_s;

   // Handshake decode and next occupancy
   always_comb begin
      push_s       = in_valid & ready_r & ~rst;
      pop_s        = valid_r & out_ready;
      count_next_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_next_s = count_r + 2'd1;
         2'b01:   count_next_s = count_r - 2'd1;
         default: count_next_s = count_r;
      endcase
   end

   // Entry storage; head always holds the oldest result
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r  <= {PAYLOAD_W{1'b0}};
         skid_r  <= {PAYLOAD_W{1'b0}};
         count_r <= 2'd0;
         ready_r <= 1'b1;
         valid_r <= 1'b0;
      end else begin
         count_r <= count_next_s;
         ready_r <= (count_next_s != 2'd2);
         valid_r <= (count_next_s != 2'd0);
         case ({push_s, pop_s})
            2'b10: begin
               if (count_r == 2'd0) head_r <= in_data;
               else                 skid_r <= in_data;
            end
            2'b01: begin
               if (count_r == 2'd2) head_r <= skid_r;
            end
            // push with pop only happens at occupancy 1
            2'b11:   head_r <= in_data;
            default: head_r <= head_r;
         endcase
      end
   end

   assign in_ready  = ready_r;
   assign out_valid = valid_r;
   assign out_data  = head_r;

endmodule
`endif

// File: rtl/alu_execute_stage.sv
// ARM execute-stage ALU with NZCV flag register and one registered cycle of latency.
// Define ALU_SKID_BUF_EN for a 2-entry output skid buffer instead of a single register.
module alu_execute_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              in_valid_in,
   output logic              in_ready_out,
   input  logic [7:0]        control_signals_in,
   input  logic [DATA_W-1:0] operand_a_in,
   input  logic [DATA_W-1:0] operand_b_in,
   input  logic              shift_carry_in,
   input  logic              set_flags_in,
   input  logic              write_en_in,
   input  logic [3:0]        rd_in,
   output logic              out_valid_out,
   input  logic              out_ready_in,
   output logic [DATA_W-1:0] result_out,
   output logic [3:0]        rd_out,
   output logic              write_en_out,
   output logic [3:0]        flags_out
);

   logic [DATA_W-1:0] a_arith_s;
   logic [DATA_W-1:0] b_arith_s;
   logic [DATA_W-1:0] b_logic_s;
   logic [DATA_W:0]   sum_s;
   logic              cin_s;
   logic [DATA_W-1:0] result_s;
   logic              carry_s;
   logic              ovf_s;
   logic [3:0]        flags_next_s;
   logic [3:0]        flags_r;
   logic              accept_s;

   // ALU datapath and candidate NZCV
   always_comb begin
      a_arith_s = operand_a_in;
      b_arith_s = operand_b_in;
      case (control_signals_in[CW_INV_MSB:CW_INV_LSB])
         INV_B:   b_arith_s = ~operand_b_in;
         INV_A:   a_arith_s = ~operand_a_in;
         default: begin
            a_arith_s = operand_a_in;
            b_arith_s = operand_b_in;
         end
      endcase

      case (control_signals_in[CW_CIN_MSB:CW_CIN_LSB])
         CIN_ZERO: cin_s = 1'b0;
         CIN_ONE:  cin_s = 1'b1;
         default:  cin_s = flags_r[FLAG_C];
      endcase

      sum_s = {1'b0, a_arith_s} + {1'b0, b_arith_s} + {{DATA_W{1'b0}}, cin_s};

      if (control_signals_in[CW_BIC_BIT]) b_logic_s = ~operand_b_in;
      else                                b_logic_s = operand_b_in;

      result_s = {DATA_W{1'b0}};
      carry_s  = shift_carry_in;
      ovf_s    = flags_r[FLAG_V];
      case (control_signals_in[CW_OP_MSB:CW_OP_LSB])
         OP_ADD: begin
            result_s = sum_s[DATA_W-1:0];
            carry_s  = sum_s[DATA_W];
            ovf_s    = (a_arith_s[DATA_W-1] == b_arith_s[DATA_W-1]) &
                       (sum_s[DATA_W-1] != a_arith_s[DATA_W-1]);
         end
         OP_AND:  result_s = operand_a_in & b_logic_s;
         OP_XOR:  result_s = operand_a_in ^ b_logic_s;
         OP_OR:   result_s = operand_a_in | b_logic_s;
         OP_MOV:  result_s = b_logic_s;
         OP_MVN:  result_s = ~b_logic_s;
         default: result_s = {DATA_W{1'b0}};
      endcase

      flags_next_s = {result_s[DATA_W-1], (result_s == {DATA_W{1'b0}}), carry_s, ovf_s};
   end

   assign accept_s = in_valid_in & in_ready_out & ~rst_in;

   // Architectural flag register, updated at acceptance when S is set
   always_ff @(posedge clk_in) begin
      if (rst_in)                         flags_r <= 4'b0000;
      else if (accept_s & set_flags_in)   flags_r <= flags_next_s;
      else                                flags_r <= flags_r;
   end

   assign flags_out = flags_r;

`ifdef ALU_SKID_BUF_EN
   logic [DATA_W+4:0] skid_out_s;

   alu_skid_buffer #(
      .PAYLOAD_W(DATA_W + 5)
   ) u_skid (
      .clk       (clk_in),
      .rst       (rst_in),
      .in_valid  (in_valid_in),
      .in_ready  (in_ready_out),
      .in_data   ({result_s, rd_in, write_en_in}),
      .out_valid (out_valid_out),
      .out_ready (out_ready_in),
      .out_data  (skid_out_s)
   );

   assign result_out   = skid_out_s[DATA_W+4:5];
   assign rd_out       = skid_out_s[4:1];
   assign write_en_out = skid_out_s[0];
`else
   logic              valid_r;
   logic [DATA_W-1:0] result_r;
   logic [3:0]        rd_r;
   logic              write_en_r;

   assign in_ready_out = ~valid_r | out_ready_in;

   // Single output register; payload only changes on acceptance
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_r    <= 1'b0;
         result_r   <= {DATA_W{1'b0}};
         rd_r       <= 4'd0;
         write_en_r <= 1'b0;
      end else if (accept_s) begin
         valid_r    <= 1'b1;
         result_r   <= result_s;
         rd_r       <= rd_in;
         write_en_r <= write_en_in;
      end else if (out_ready_in) begin
         valid_r    <= 1'b0;
      end
   end

   assign out_valid_out = valid_r;
   assign result_out    = result_r;
   assign rd_out        = rd_r;
   assign write_en_out  = write_en_r;
`endif

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed, table-driven bench for alu_execute_stage; expectation on stall depth
// follows ALU_SKID_BUF_EN.
module tb_alu_execute_stage;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        in_valid_in;
   logic        in_ready_out;
   logic [7:0]  control_signals_in;
   logic [31:0] operand_a_in;
   logic [31:0] operand_b_in;
   logic        shift_carry_in;
   logic        set_flags_in;
   logic        write_en_in;
   logic [3:0]  rd_in;
   logic        out_valid_out;
   logic        out_ready_in;
   logic [31:0] result_out;
   logic [3:0]  rd_out;
   logic        write_en_out;
   logic [3:0]  flags_out;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   alu_execute_stage #(.DATA_W(32)) dut (
      .clk_in             (clk),
      .rst_in             (rst_in),
      .in_valid_in        (in_valid_in),
      .in_ready_out       (in_ready_out),
      .control_signals_in (control_signals_in),
      .operand_a_in       (operand_a_in),
      .operand_b_in       (operand_b_in),
      .shift_carry_in     (shift_carry_in),
      .set_flags_in       (set_flags_in),
      .write_en_in        (write_en_in),
      .rd_in              (rd_in),
      .out_valid_out      (out_valid_out),
      .out_ready_in       (out_ready_in),
      .result_out         (result_out),
      .rd_out             (rd_out),
      .write_en_out       (write_en_out),
      .flags_out          (flags_out)
   );

   typedef struct {
      logic [7:0]  cw;
      logic [31:0] a;
      logic [31:0] b;
      logic        sc;
      logic        s;
      logic [31:0] res;
      logic [3:0]  nzcv;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] cw, input logic [31:0] a,
                        input logic [31:0] b, input logic sc, input logic s,
                        input logic we, input logic [3:0] rd);
      in_valid_in        = v;
      control_signals_in = cw;
      operand_a_in       = a;
      operand_b_in       = b;
      shift_carry_in     = sc;
      set_flags_in       = s;
      write_en_in        = we;
      rd_in              = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin : main
      int          acc;
      int          j;
      int          got;
      int          exp_acc;
      logic [31:0] got_res[$];
      logic [3:0]  got_rd[$];

`ifdef ALU_SKID_BUF_EN
      exp_acc = 2;
`else
      exp_acc = 1;
`endif

      vt[0]  = '{8'b01_01_0_000, 32'd5,          32'd7,          1'b0, 1'b1, 32'hFFFF_FFFE, 4'b1000};
      vt[1]  = '{8'b00_00_0_000, 32'hFFFF_FFFF,  32'd1,          1'b0, 1'b1, 32'h0000_0000, 4'b0110};
      vt[2]  = '{8'b10_00_0_000, 32'd0,          32'd0,          1'b0, 1'b0, 32'h0000_0001, 4'b0110};
      vt[3]  = '{8'b00_00_0_000, 32'h7FFF_FFFF,  32'd1,          1'b0, 1'b1, 32'h8000_0000, 4'b1001};
      vt[4]  = '{8'b00_00_1_010, 32'hFF00_FF00,  32'h0F0F_0F0F,  1'b1, 1'b1, 32'hF000_F000, 4'b1011};
      vt[5]  = '{8'b00_00_0_001, 32'h0000_F0F0,  32'h0F00_0000,  1'b0, 1'b1, 32'h0F00_F0F0, 4'b0001};
      vt[6]  = '{8'b00_00_0_100, 32'hAAAA_AAAA,  32'hAAAA_AAAA,  1'b0, 1'b1, 32'h0000_0000, 4'b0101};
      vt[7]  = '{8'b00_00_0_101, 32'hDEAD_BEEF,  32'h1234_5678,  1'b1, 1'b0, 32'h1234_5678, 4'b0101};
      vt[8]  = '{8'b00_00_0_011, 32'd0,          32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1011};
      vt[9]  = '{8'b01_10_0_000, 32'd3,          32'd10,         1'b0, 1'b1, 32'h0000_0007, 4'b0010};
      vt[10] = '{8'b10_01_0_000, 32'h8000_0000,  32'd1,          1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0011};
      vt[11] = '{8'b00_00_0_110, 32'd5,          32'd5,          1'b0, 1'b1, 32'h0000_0000, 4'b0101};
      vt[12] = '{8'b00_11_0_000, 32'd2,          32'd3,          1'b0, 1'b1, 32'h0000_0005, 4'b0000};
      vt[13] = '{8'b10_01_0_000, 32'd10,         32'd3,          1'b0, 1'b1, 32'h0000_0006, 4'b0010};

      // Reset with an op offered throughout: it must not be accepted
      rst_in       = 1'b1;
      out_ready_in = 1'b1;
      drive(1'b1, 8'b00_00_0_000, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1, 4'd9);
      tick();
      tick();
      chk("reset_out_valid", {31'd0, out_valid_out}, 32'd0);
      chk("reset_flags", {28'd0, flags_out}, 32'd0);
      chk("reset_result", result_out, 32'd0);
      chk("reset_rd", {28'd0, rd_out}, 32'd0);
      rst_in = 1'b0;
      drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      chk("post_reset_in_ready", {31'd0, in_ready_out}, 32'd1);
      tick();
      chk("post_reset_no_output", {31'd0, out_valid_out}, 32'd0);
      chk("post_reset_flags", {28'd0, flags_out}, 32'd0);

      // Back-to-back table at full throughput
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, vt[i].cw, vt[i].a, vt[i].b, vt[i].sc, vt[i].s, i[0], i[3:0]);
         @(negedge clk);
         chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready_out}, 32'd1);
         tick();
         chk($sformatf("v%0d_valid", i), {31'd0, out_valid_out}, 32'd1);
         chk($sformatf("v%0d_result", i), result_out, vt[i].res);
         chk($sformatf("v%0d_nzcv", i), {28'd0, flags_out}, {28'd0, vt[i].nzcv});
         chk($sformatf("v%0d_rd", i), {28'd0, rd_out}, {28'd0, i[3:0]});
         chk($sformatf("v%0d_we", i), {31'd0, write_en_out}, {31'd0, i[0]});
      end
      drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      chk("drained", {31'd0, out_valid_out}, 32'd0);

      // Backpressure: three MOV ops offered during a 6-cycle stall
      out_ready_in = 1'b0;
      acc = 0;
      j   = 0;
      repeat (6) begin
         if (j < 3) drive(1'b1, 8'b00_00_0_101, 32'd0, 32'h111 * (j + 1), 1'b0, 1'b0, 1'b1, 4'(j + 1));
         else       drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
         @(negedge clk);
         if (in_valid_in && in_ready_out) begin
            acc++;
            j++;
         end
         tick();
      end
      chk("stall_accepted", acc, exp_acc);
      chk("stall_in_ready", {31'd0, in_ready_out}, 32'd0);
      chk("stall_valid", {31'd0, out_valid_out}, 32'd1);
      chk("stall_result_stable", result_out, 32'h111);
      chk("stall_rd_stable", {28'd0, rd_out}, 32'd1);

      // Release: all three must emerge once, in order
      out_ready_in = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 3; c++) begin
         if (j < 3) drive(1'b1, 8'b00_00_0_101, 32'd0, 32'h111 * (j + 1), 1'b0, 1'b0, 1'b1, 4'(j + 1));
         else       drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
         @(negedge clk);
         if (out_valid_out) begin
            got_res.push_back(result_out);
            got_rd.push_back(rd_out);
            got++;
         end
         if (in_valid_in && in_ready_out) j++;
         tick();
      end
      drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      chk("release_count", got, 3);
      for (int k = 0; k < got; k++) begin
         chk($sformatf("release%0d_result", k), got_res[k], 32'h111 * (k + 1));
         chk($sformatf("release%0d_rd", k), {28'd0, got_rd[k]}, k + 1);
      end
      @(negedge clk);
      chk("release_no_duplicate", {31'd0, out_valid_out}, 32'd0);
      tick();

      // Fill under stall with flag-setting ops, then reset mid-stall
      out_ready_in = 1'b0;
      repeat (3) begin
         drive(1'b1, 8'b00_00_0_011, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 4'd7);
         tick();
      end
      chk("prefill_full", {31'd0, in_ready_out}, 32'd0);
      chk("prefill_flags", {28'd0, flags_out}, {28'd0, 4'b1010});
      rst_in = 1'b1;
      drive(1'b1, 8'b00_00_0_000, 32'd1, 32'd1, 1'b0, 1'b1, 1'b1, 4'd5);
      tick();
      chk("midreset_valid", {31'd0, out_valid_out}, 32'd0);
      chk("midreset_flags", {28'd0, flags_out}, 32'd0);
      chk("midreset_result", result_out, 32'd0);
      rst_in       = 1'b0;
      out_ready_in = 1'b1;
      drive(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("no_stale_%0d", c), {31'd0, out_valid_out}, 32'd0);
      end
      chk("post_midreset_flags", {28'd0, flags_out}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
